inst_fetch: RTL and testbench

Instruction fetch front end that drives the synchronous instruction memory and presents fetched words to decode. It owns the program counter, issues one read per cycle, and tracks which returned word is valid across stalls, redirects and the end-of-program marker. It sits between the PC/branch logic and decode, and it is the requester side of the memory's address/hazard/data interface.

---
 rtl/inst_fetch.sv | 90 +++++++++
 tb/tb_inst_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, issues one synchronous memory
// read per cycle and qualifies the returned word for decode across stalls,
// redirects and the all-zero end-of-program marker.
module inst_fetch #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_hazard,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              inst_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    // Fetch-side state: next address to request, address of the word now
    // returning, whether that return is live, halt flag, delivered count.
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] issued_q;
    logic              fvalid_q;
    logic              halted_q;
    logic [15:0]       count_q;

    logic              word_is_zero;
    logic              halt_now;
    logic              deliver;

    // Qualify the word coming back from memory this cycle.
    always_comb begin
        word_is_zero = (imem_data == '0);
        halt_now     = fvalid_q & word_is_zero;
        inst_valid   = fvalid_q & ~halted_q & ~word_is_zero;
        // A word only counts as delivered if decode actually consumes it:
        // not while the pipe is frozen and not when a redirect squashes it.
        deliver      = inst_valid & ~stall & ~redirect_valid;
    end

    // PC / return-tracking update; redirect beats stall, stall beats halt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            issued_q <= RESET_PC;
            fvalid_q <= 1'b0;
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            // The word in flight belongs to the old path, so squash it.
            pc_q     <= redirect_pc;
            fvalid_q <= 1'b0;
            halted_q <= 1'b0;
        end else if (stall) begin
            // Memory holds its output too, so everything simply freezes.
            pc_q     <= pc_q;
        end else if (halted_q || halt_now) begin
            halted_q <= 1'b1;
            fvalid_q <= 1'b0;
        end else begin
            issued_q <= pc_q;
            pc_q     <= pc_q + 1'b1;
            fvalid_q <= 1'b1;
        end
    end

    // Count instructions handed to decode (wraps at 16 bits).
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (deliver) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Memory request side and decode-facing outputs.
    always_comb begin
        imem_addr   = pc_q;
        imem_hazard = stall & ~redirect_valid;
        inst_out    = imem_data;
        pc_out      = issued_q;
        halted      = halted_q;
        fetch_count = count_q;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: two instances share clock and reset, one
// with RESET_PC=0 and a short program ending in zero words, one with
// RESET_PC=254 over a fully nonzero memory to exercise PC wrap.
module tb_inst_fetch;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;

    logic [AW-1:0] addr_a, pc_out_a;
    logic          hazard_a, valid_a, halted_a;
    logic [DW-1:0] rdata_a, inst_a;
    logic [15:0]   count_a;

    logic [AW-1:0] addr_b, pc_out_b;
    logic          hazard_b, valid_b, halted_b;
    logic [DW-1:0] rdata_b, inst_b;
    logic [15:0]   count_b;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'd0)) dut_a (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(addr_a), .imem_hazard(hazard_a), .imem_data(rdata_a),
        .inst_out(inst_a), .pc_out(pc_out_a), .inst_valid(valid_a),
        .halted(halted_a), .fetch_count(count_a)
    );

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'd254)) dut_b (
        .clk(clk), .rst(rst), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(8'd0),
        .imem_addr(addr_b), .imem_hazard(hazard_b), .imem_data(rdata_b),
        .inst_out(inst_b), .pc_out(pc_out_b), .inst_valid(valid_b),
        .halted(halted_b), .fetch_count(count_b)
    );

    // Synchronous instruction memories: hold output while hazard is high.
    always @(posedge clk) begin
        if (!hazard_a) rdata_a <= mem_a[addr_a];
        if (!hazard_b) rdata_b <= mem_b[addr_b];
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Program A: load-like words for 0..18, zero (end marker) from 19 on.
    function automatic logic [31:0] word_a(input int i);
        logic [31:0] w;
        w = 32'(i << 15) | 32'((i + 1) << 7) | 32'd3;
        return (i < 19) ? w : 32'd0;
    endfunction

    function automatic logic [31:0] word_b(input int i);
        return 32'h1000_0000 | 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input int pc);
        chk($sformatf("valid@%0d", pc), {31'd0, valid_a}, 32'd1);
        chk($sformatf("pc_out@%0d", pc), {24'd0, pc_out_a}, 32'(pc));
        chk($sformatf("inst@%0d", pc), inst_a, word_a(pc));
    endtask

    logic [31:0] first_words [3];
    logic [7:0]  wrap_pcs [4];

    initial begin
        first_words[0] = 32'h0000_0083;
        first_words[1] = 32'h0000_8103;
        first_words[2] = 32'h0001_0183;
        wrap_pcs[0] = 8'd254;
        wrap_pcs[1] = 8'd255;
        wrap_pcs[2] = 8'd0;
        wrap_pcs[3] = 8'd1;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = word_a(i);
            mem_b[i] = word_b(i);
        end

        rst = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();

        // Reset state
        chk("rst imem_addr", {24'd0, addr_a}, 32'd0);
        chk("rst pc_out", {24'd0, pc_out_a}, 32'd0);
        chk("rst valid", {31'd0, valid_a}, 32'd0);
        chk("rst halted", {31'd0, halted_a}, 32'd0);
        chk("rst count", {16'd0, count_a}, 32'd0);
        chk("rst hazard", {31'd0, hazard_a}, 32'd0);
        chk("rst b imem_addr", {24'd0, addr_b}, 32'd254);
        chk("rst b pc_out", {24'd0, pc_out_b}, 32'd254);
        stall = 1'b1;
        #1;
        chk("rst hazard=stall", {31'd0, hazard_a}, 32'd1);
        stall = 1'b0;

        // Sequential fetch on A and wrap on B
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) begin
                exp_a(k);
                chk($sformatf("seq word%0d", k), inst_a, first_words[k]);
            end
            chk($sformatf("wrap pc%0d", k), {24'd0, pc_out_b}, {24'd0, wrap_pcs[k]});
            chk($sformatf("wrap inst%0d", k), inst_b, word_b(int'(wrap_pcs[k])));
            chk($sformatf("wrap valid%0d", k), {31'd0, valid_b}, 32'd1);
        end
        chk("count after 3", {16'd0, count_a}, 32'd3);

        // Stall three cycles on word 5
        tick(); exp_a(4);
        tick(); exp_a(5);
        chk("count pre-stall", {16'd0, count_a}, 32'd5);
        stall = 1'b1;
        #1;
        chk("stall hazard", {31'd0, hazard_a}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            tick();
            exp_a(5);
            chk($sformatf("stall count%0d", j), {16'd0, count_a}, 32'd5);
        end
        stall = 1'b0;
        tick(); exp_a(6);
        chk("count post-stall", {16'd0, count_a}, 32'd6);

        // Run into the end-of-program marker
        for (int p = 7; p <= 18; p++) begin
            tick();
            exp_a(p);
        end
        tick();
        chk("zero word valid", {31'd0, valid_a}, 32'd0);
        chk("zero word halted", {31'd0, halted_a}, 32'd0);
        chk("count at halt", {16'd0, count_a}, 32'd19);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("halted%0d", j), {31'd0, halted_a}, 32'd1);
            chk($sformatf("halt valid%0d", j), {31'd0, valid_a}, 32'd0);
            chk($sformatf("halt count%0d", j), {16'd0, count_a}, 32'd19);
            chk($sformatf("halt addr%0d", j), {24'd0, addr_a}, 32'd20);
        end

        // Redirect out of halt back to 0
        redirect_valid = 1'b1;
        redirect_pc = 8'd0;
        tick();
        redirect_valid = 1'b0;
        chk("unhalt halted", {31'd0, halted_a}, 32'd0);
        chk("unhalt valid", {31'd0, valid_a}, 32'd0);
        chk("unhalt addr", {24'd0, addr_a}, 32'd0);
        for (int p = 0; p <= 4; p++) begin
            tick();
            exp_a(p);
        end
        chk("count refetch", {16'd0, count_a}, 32'd23);

        // Redirect to 16 together with stall: redirect wins
        redirect_valid = 1'b1;
        redirect_pc = 8'd16;
        stall = 1'b1;
        #1;
        chk("redir hazard", {31'd0, hazard_a}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        chk("redir squash", {31'd0, valid_a}, 32'd0);
        chk("redir addr", {24'd0, addr_a}, 32'd16);
        chk("redir count", {16'd0, count_a}, 32'd23);
        tick(); exp_a(16);
        tick(); exp_a(17);
        chk("count at 17", {16'd0, count_a}, 32'd24);

        // Stream to 10, then reset mid-operation
        redirect_valid = 1'b1;
        redirect_pc = 8'd8;
        tick();
        redirect_valid = 1'b0;
        chk("redir8 squash", {31'd0, valid_a}, 32'd0);
        tick(); exp_a(8);
        tick(); exp_a(9);
        tick(); exp_a(10);
        chk("count at 10", {16'd0, count_a}, 32'd26);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid rst valid", {31'd0, valid_a}, 32'd0);
        chk("mid rst halted", {31'd0, halted_a}, 32'd0);
        chk("mid rst count", {16'd0, count_a}, 32'd0);
        chk("mid rst addr", {24'd0, addr_a}, 32'd0);
        chk("mid rst b addr", {24'd0, addr_b}, 32'd254);
        tick(); exp_a(0);
        chk("restart count0", {16'd0, count_a}, 32'd0);
        tick(); exp_a(1);
        chk("restart count1", {16'd0, count_a}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
